// File: rtl/game_reg_bank_if.sv
// rtl/game_reg_bank_if.sv - processor register write/readback bus for game_reg_bank
interface game_reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/game_reg_bank.sv
// rtl/game_reg_bank.sv - game register bank with frame-synchronous commit, seed and frame counters
// GAME_REG_DOUBLE_BUFFER_EN selects shadow/live double buffering; otherwise writes go live at once.
module game_reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 5
) (
    input  logic                       clock,
    input  logic                       resetn,
    game_reg_bank_if.slave             bus,
    input  logic                       frame_sync,
    output logic [NUM_REGS*DATA_W-1:0] live_out,
    output logic [NUM_REGS-1:0]        dirty,
    output logic [DATA_W-1:0]          frame_count,
    output logic [DATA_W-1:0]          seed
);
    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] rd_val;

`ifdef GAME_REG_DOUBLE_BUFFER_EN
    logic [DATA_W-1:0]   live [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q;

    // Commit uses the pre-edge shadow, so a write racing frame_sync waits for the next sync.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
                live[i]   <= '0;
            end
            dirty_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
                    shadow[i]  <= bus.wr_data;
                    dirty_q[i] <= 1'b1;
                end else if (frame_sync) begin
                    dirty_q[i] <= 1'b0;
                end
                if (frame_sync && dirty_q[i]) begin
                    live[i] <= shadow[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_live
        assign live_out[g*DATA_W +: DATA_W] = live[g];
    end
    assign dirty = dirty_q;
`else
    // Single copy: the shadow register is also the live register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
                    shadow[i] <= bus.wr_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_live
        assign live_out[g*DATA_W +: DATA_W] = shadow[g];
    end
    assign dirty = '0;
`endif

    // Out-of-range read addresses match no channel and return zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr == ADDR_W'(i)) begin
                rd_val = shadow[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.rd_data <= '0;
            frame_count <= '0;
            seed        <= '0;
        end else begin
            bus.rd_data <= rd_val;
            seed        <= seed + 1'b1;
            if (frame_sync) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_game_reg_bank.sv
// tb/tb_game_reg_bank.sv - self-checking bench for game_reg_bank against a behavioural model
module tb_game_reg_bank;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 5;
`ifdef GAME_REG_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic frame_sync = 1'b0;
    logic [NUM_REGS*DATA_W-1:0] live_out;
    logic [NUM_REGS-1:0]        dirty;
    logic [DATA_W-1:0]          frame_count;
    logic [DATA_W-1:0]          seed;

    game_reg_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    game_reg_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus),
        .frame_sync  (frame_sync),
        .live_out    (live_out),
        .dirty       (dirty),
        .frame_count (frame_count),
        .seed        (seed)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [DATA_W-1:0] m_shadow [NUM_REGS];
    logic [DATA_W-1:0] m_live   [NUM_REGS];
    bit                m_dirty  [NUM_REGS];
    logic [DATA_W-1:0] m_rd, m_fc, m_seed;

    int total = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_shadow[i] = '0;
            m_live[i]   = '0;
            m_dirty[i]  = 1'b0;
        end
        m_rd = '0; m_fc = '0; m_seed = '0;
    endtask

    task automatic model_cycle(input bit we, input int wa, input logic [DATA_W-1:0] wd,
                               input int ra, input bit fs);
        m_rd = (ra < NUM_REGS) ? m_shadow[ra] : '0;
        if (DB) begin
            if (fs)
                for (int i = 0; i < NUM_REGS; i++)
                    if (m_dirty[i]) begin
                        m_live[i]  = m_shadow[i];
                        m_dirty[i] = 1'b0;
                    end
            if (we && wa < NUM_REGS) begin
                m_shadow[wa] = wd;
                m_dirty[wa]  = 1'b1;
            end
        end else if (we && wa < NUM_REGS) begin
            m_shadow[wa] = wd;
            m_live[wa]   = wd;
        end
        if (fs) m_fc = m_fc + 1;
        m_seed = m_seed + 1;
    endtask

    task automatic check_all(input string tag);
        logic [NUM_REGS*DATA_W-1:0] exp_live;
        logic [NUM_REGS-1:0]        exp_dirty;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_live[i*DATA_W +: DATA_W] = m_live[i];
            exp_dirty[i] = m_dirty[i];
        end
        chk({tag, ".live"},  256'(live_out),    256'(exp_live));
        chk({tag, ".dirty"}, 256'(dirty),       256'(exp_dirty));
        chk({tag, ".rd"},    256'(bus.rd_data), 256'(m_rd));
        chk({tag, ".fc"},    256'(frame_count), 256'(m_fc));
        chk({tag, ".seed"},  256'(seed),        256'(m_seed));
    endtask

    task automatic step(input string tag, input bit we, input int wa, input logic [DATA_W-1:0] wd,
                        input int ra, input bit fs);
        bus.wr_en   = we;
        bus.wr_addr = ADDR_W'(wa);
        bus.wr_data = wd;
        bus.rd_addr = ADDR_W'(ra);
        frame_sync  = fs;
        @(posedge clock);
        #1;
        model_cycle(we, wa, wd, ra, fs);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n, input int ra);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 0, '0, ra, 1'b0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        model_reset();
        #12;
        check_all("in_reset");
        @(posedge clock); #1;
        resetn = 1'b1;
        idle("idle", 10, 0);
        chk("seed_after_10", 256'(seed), 256'(10));
        chk("live_zero_idle", 256'(live_out), 256'(0));

        // Write ch1 = 0x64, wait, then frame_sync
        step("wr_ch1", 1'b1, 1, 32'h64, 1, 1'b0);
        chk("ch1_live_after_wr", 256'(live_out[1*DATA_W +: DATA_W]), DB ? 256'(0) : 256'(32'h64));
        chk("ch1_dirty_after_wr", 256'(dirty[1]), DB ? 256'(1) : 256'(0));
        idle("wait1", 4, 1);
        step("fs1", 1'b0, 0, '0, 1, 1'b1);
        chk("ch1_live_after_fs", 256'(live_out[1*DATA_W +: DATA_W]), 256'(32'h64));
        chk("ch1_dirty_after_fs", 256'(dirty[1]), 256'(0));

        // Write racing frame_sync on the same channel
        step("wr_ch2_5", 1'b1, 2, 32'd5, 2, 1'b0);
        step("wr_ch2_9_fs", 1'b1, 2, 32'd9, 2, 1'b1);
        chk("ch2_live_race", 256'(live_out[2*DATA_W +: DATA_W]), DB ? 256'(5) : 256'(9));
        chk("ch2_dirty_race", 256'(dirty[2]), DB ? 256'(1) : 256'(0));
        step("rd_ch2", 1'b0, 0, '0, 2, 1'b0);
        chk("ch2_shadow_race", 256'(bus.rd_data), 256'(9));
        step("fs2", 1'b0, 0, '0, 2, 1'b1);
        chk("ch2_live_next_fs", 256'(live_out[2*DATA_W +: DATA_W]), 256'(9));

        // Out-of-range write and read
        step("wr_oob", 1'b1, NUM_REGS, 32'hDEAD, NUM_REGS, 1'b0);
        step("rd_oob", 1'b0, 0, '0, NUM_REGS, 1'b0);
        chk("rd_oob_zero", 256'(bus.rd_data), 256'(0));
        chk("dirty_oob", 256'(dirty), 256'(0));

        // Read-during-write returns the old value
        step("wr_ch0_3", 1'b1, 0, 32'd3, 0, 1'b0);
        step("wr_ch0_7", 1'b1, 0, 32'd7, 0, 1'b0);
        chk("rdw_old", 256'(bus.rd_data), 256'(3));
        step("rd_ch0", 1'b0, 0, '0, 0, 1'b0);
        chk("rdw_new", 256'(bus.rd_data), 256'(7));
        step("fs3", 1'b0, 0, '0, 0, 1'b1);

        // Asynchronous reset while ch1/ch2 are dirty
        step("wr_ch1_d", 1'b1, 1, 32'hAA, 1, 1'b0);
        step("wr_ch2_d", 1'b1, 2, 32'hBB, 2, 1'b0);
        chk("dirty_pre_reset", 256'(dirty), DB ? 256'(6) : 256'(0));
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        resetn = 1'b1;
        step("fs_after_rst", 1'b0, 0, '0, 1, 1'b1);
        chk("live_after_rst_fs", 256'(live_out), 256'(0));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step("rand", $urandom_range(0, 1) == 1, int'($urandom_range(0, NUM_REGS + 1)), $urandom,
                 int'($urandom_range(0, NUM_REGS + 1)), $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/game_reg_bank.md
# game_reg_bank

Parametrised bank of processor-writable game registers: game state, bird Y, score and future channels. Each write goes into a shadow copy. Dirty shadows are committed to the live outputs on a frame-sync pulse, so the renderer never sees a half-updated frame. The bank sits between the processor's register-write strobe/value path and the render and game-logic blocks. It also provides a free-running seed counter and a frame counter.

## Interface
Parameters:
- DATA_W, 32, width of each register
- NUM_REGS, 8, number of register channels (2..32)
- ADDR_W, 5, address width; must satisfy 2^ADDR_W >= NUM_REGS

Ports:
- clock  in  1  single system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, one write per cycle
- wr_addr  in  ADDR_W  target register index
- wr_data  in  DATA_W  value to write
- rd_addr  in  ADDR_W  readback index
- rd_data  out  DATA_W  registered readback of the shadow copy
- frame_sync  in  1  single-cycle pulse, already synchronous to clock (VGA vertical blank)
- live_out  out  NUM_REGS*DATA_W  flattened live registers; channel i occupies bits [i*DATA_W +: DATA_W]
- dirty  out  NUM_REGS  per-channel flag: shadow differs from a committed write
- frame_count  out  DATA_W  number of frame_sync pulses seen
- seed  out  DATA_W  free-running cycle counter for the random generator

## Operation
- Reset (resetn low, asynchronous):
  - all shadow and live registers = 0
  - dirty = 0, rd_data = 0, frame_count = 0, seed = 0
- seed increments by 1 every cycle and wraps modulo 2^DATA_W.
- Write: if wr_en is high and wr_addr < NUM_REGS, shadow[wr_addr] <= wr_data and dirty[wr_addr] <= 1.
  - A write with wr_addr >= NUM_REGS is ignored; no state changes.
- Commit: on a cycle with frame_sync high, every channel with dirty = 1 copies shadow to live, and its dirty bit clears.
  - Channels with dirty = 0 keep their live value.
  - frame_count increments and wraps modulo 2^DATA_W.
- Simultaneous wr_en and frame_sync:
  - All other dirty channels commit their pre-edge shadow values.
  - The written channel commits its pre-edge shadow value only if it was already dirty.
  - The new value lands in shadow with dirty = 1 and commits at the next frame_sync.
- Repeated writes to one channel between syncs: last write wins; only that value is committed.
- Readback: rd_data <= shadow[rd_addr] (pre-edge value), so a read and write to the same address in one cycle returns the old value.
  - If rd_addr >= NUM_REGS, rd_data <= 0.
- Reset mid-frame: pending dirty writes are discarded.
- No state machine beyond the per-channel clean and dirty states:
  - clean to dirty on a valid write
  - dirty to clean on frame_sync without a concurrent write to that channel

## Timing
- Write to shadow: visible on rd_data 2 edges after wr_en (1 edge to write, 1 edge to register the read).
- Commit latency: live_out changes on the same edge that samples frame_sync high. Worst case from write to live is one full frame.
- dirty is valid 1 edge after wr_en and clears on the frame_sync edge.
- frame_count updates on the frame_sync edge. seed updates every edge.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Configuration
- GAME_REG_DOUBLE_BUFFER_EN defined: shadow and commit behaviour as above.
- GAME_REG_DOUBLE_BUFFER_EN undefined:
  - A valid write updates shadow and live on the same edge.
  - dirty is held at 0 and frame_sync affects only frame_count.
  - rd_data reads the common value.
  - All other behaviour is unchanged.

## Test plan
- Reset then idle 10 cycles: all live_out, dirty and rd_data = 0; seed = 10; frame_count = 0.
- Double-buffer build: write ch1 = 0x64 at cycle 3, frame_sync at cycle 8.
  - live ch1 = 0 through cycle 8 and 0x64 after the cycle-8 edge.
  - dirty[1] is 1 from cycle 4 and 0 after cycle 8.
- Write ch2 = 5 and, in the same cycle as frame_sync, write ch2 = 9.
  - After the edge: live ch2 = 5, shadow ch2 = 9, dirty[2] = 1.
  - Next frame_sync: live ch2 = 9.
- Write to wr_addr = NUM_REGS with 0xDEAD: no dirty bit set, no live change; rd_data at that address = 0.
- Read and write ch0 in the same cycle (old value 3, new value 7): rd_data = 3; the next read returns 7.
- Pull resetn low asynchronously while dirty = 0x06: all outputs are 0 immediately; the following frame_sync commits nothing.
- Build without the macro: a write to ch0 updates live_out on the next edge and dirty stays 0.
